// File: rtl/rtl_result_fifo_pkg.sv
// Shared types for the result FIFO: the buffered entry layout and default sizing.
package rtl_fifo_pkg;

  localparam int RESULT_W          = 5;
  localparam int RESULT_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [RESULT_W-1:0] data;
    logic                orr;
    logic                andr;
  } result_entry_t;

endpackage

// File: rtl/rtl_result_fifo_if.sv
// Producer/consumer handshake bundle of the result FIFO, plus its occupancy/transfer status.
interface rtl_result_fifo_if
  import rtl_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int DEPTH = RESULT_FIFO_DEPTH,
  parameter int CNT_W = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data;
  logic             enq_orr;
  logic             enq_andr;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_data;
  logic             deq_orr;
  logic             deq_andr;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] xfer_count;

  // master drives entries in and drains them; slave is the FIFO itself
  modport master (
    output enq_valid, enq_data, enq_orr, enq_andr, deq_ready,
    input  enq_ready, deq_valid, deq_data, deq_orr, deq_andr, count, xfer_count
  );

  modport slave (
    input  enq_valid, enq_data, enq_orr, enq_andr, deq_ready,
    output enq_ready, deq_valid, deq_data, deq_orr, deq_andr, count, xfer_count
  );

endinterface

// File: rtl/rtl_result_fifo.sv
// Result buffer behind ready/valid: holds (xor result, orr, andr) entries and drains them in order.
module rtl_result_fifo
  import rtl_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_W,
  parameter int DEPTH = RESULT_FIFO_DEPTH,
  parameter int CNT_W = 16
) (
  input logic          CLK,
  input logic          ASYNCRESET,
  rtl_result_fifo_if.slave fifo
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  result_entry_t    mem [DEPTH];
  result_entry_t    head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count_q;
  logic [CNT_W-1:0] xfer_q;
  logic             empty;
  logic             full;
  logic             enq_fire;
  logic             deq_fire;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  assign fifo.enq_ready = !full && !ASYNCRESET;
  assign fifo.deq_valid = !empty;
  assign enq_fire       = fifo.enq_valid && fifo.enq_ready;
  assign deq_fire       = fifo.deq_valid && fifo.deq_ready;

  // Storage is not reset; the output mux masks stale contents when nothing is held.
  assign head          = mem[rd_ptr[IDX_W-1:0]];
  assign fifo.deq_data = fifo.deq_valid ? head.data : '0;
  assign fifo.deq_orr  = fifo.deq_valid && head.orr;
  assign fifo.deq_andr = fifo.deq_valid && head.andr;

  assign fifo.count      = count_q;
  assign fifo.xfer_count = xfer_q;

  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      mem[wr_ptr[IDX_W-1:0]] <= '{data: fifo.enq_data, orr: fifo.enq_orr, andr: fifo.enq_andr};
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      xfer_q  <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        xfer_q <= xfer_q + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rtl_result_fifo.sv
// Scoreboard bench for rtl_result_fifo: a queue model of accepted entries checked against the DUT.
module tb_rtl_result_fifo;
  import rtl_fifo_pkg::*;

  localparam int DEPTH = RESULT_FIFO_DEPTH;

  logic CLK;
  logic ASYNCRESET;
  int   checks = 0;
  int   fails  = 0;
  int   mxfer  = 0;
  result_entry_t sb[$];

  rtl_result_fifo_if #(.WIDTH(RESULT_W), .DEPTH(DEPTH), .CNT_W(16)) bus ();

  rtl_result_fifo #(.WIDTH(RESULT_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .fifo      (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle of stimulus and advance the model as the DUT should at the edge.
  task automatic step(input logic v, input logic [RESULT_W-1:0] d, input logic o, input logic a,
                      input logic r);
    bit fire_e, fire_d;
    bus.enq_valid = v; bus.enq_data = d; bus.enq_orr = o; bus.enq_andr = a; bus.deq_ready = r;
    fire_e = v && (sb.size() < DEPTH);
    fire_d = r && (sb.size() > 0);
    @(posedge CLK); #1;
    if (fire_d) void'(sb.pop_front());
    if (fire_e) begin sb.push_back('{data: d, orr: o, andr: a}); mxfer++; end
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b0;
  endtask

  task automatic test_reset();
    ASYNCRESET = 1'b1;
    bus.enq_valid = 1'b0; bus.enq_data = '0; bus.enq_orr = 1'b0; bus.enq_andr = 1'b0;
    bus.deq_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (bus.enq_ready !== 1'b0) begin fails++; $display("FAIL rst_enq_ready: got %b want 0", bus.enq_ready); end
    checks++; if (bus.deq_valid !== 1'b0) begin fails++; $display("FAIL rst_deq_valid: got %b want 0", bus.deq_valid); end
    checks++; if (bus.count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    checks++; if (bus.xfer_count !== 16'd0) begin fails++; $display("FAIL rst_xfer: got %0d want 0", bus.xfer_count); end
    checks++; if (bus.deq_data !== 5'd0) begin fails++; $display("FAIL rst_deq_data: got %h want 00", bus.deq_data); end
    ASYNCRESET = 1'b0;
    sb.delete(); mxfer = 0;
    @(posedge CLK); #1;
    checks++; if (bus.enq_ready !== 1'b1) begin fails++; $display("FAIL rel_enq_ready: got %b want 1", bus.enq_ready); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.enq_ready !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b want 1", i, bus.enq_ready); end
      step(1'b1, 5'(i), 1'b1, 1'b0, 1'b0);
    end
    checks++; if (bus.count !== 3'(sb.size())) begin fails++; $display("FAIL fill_count: got %0d want %0d", bus.count, sb.size()); end
    checks++; if (bus.enq_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", bus.enq_ready); end
    step(1'b1, 5'h1F, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.xfer_count !== 16'(mxfer)) begin fails++; $display("FAIL full_xfer: got %0d want %0d", bus.xfer_count, mxfer); end
    checks++; if (bus.count !== 3'(sb.size())) begin fails++; $display("FAIL full_count: got %0d want %0d", bus.count, sb.size()); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.deq_valid !== 1'b1) begin fails++; $display("FAIL drain_valid%0d: got %b want 1", i, bus.deq_valid); end
      checks++; if (bus.deq_data !== sb[0].data) begin fails++; $display("FAIL drain_data%0d: got %h want %h", i, bus.deq_data, sb[0].data); end
      step(1'b0, 5'h0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (bus.deq_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b want 0", bus.deq_valid); end
    checks++; if (bus.count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", bus.count); end
    step(1'b0, 5'h0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.count !== 3'(sb.size())) begin fails++; $display("FAIL empty_deq_count: got %0d want %0d", bus.count, sb.size()); end
  endtask

  task automatic test_simultaneous();
    logic [RESULT_W-1:0] d;
    logic o, a;
    step(1'b1, 5'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'h12, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d = 5'($urandom); o = 1'($urandom); a = 1'($urandom);
      checks++; if (bus.count !== 3'd2) begin fails++; $display("FAIL simul_count%0d: got %0d want 2", i, bus.count); end
      checks++; if ({bus.deq_data, bus.deq_orr, bus.deq_andr} !== sb[0]) begin fails++; $display("FAIL simul_head%0d: got %h want %h", i, {bus.deq_data, bus.deq_orr, bus.deq_andr}, sb[0]); end
      step(1'b1, d, o, a, 1'b1);
    end
    while (sb.size() > 0) begin
      checks++; if ({bus.deq_data, bus.deq_orr, bus.deq_andr} !== sb[0]) begin fails++; $display("FAIL simul_tail: got %h want %h", {bus.deq_data, bus.deq_orr, bus.deq_andr}, sb[0]); end
      step(1'b0, 5'h0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_full_with_deq();
    for (int i = 0; i < 4; i++) step(1'b1, 5'(5'h08 + i), 1'b0, 1'b0, 1'b0);
    checks++; if (bus.deq_data !== sb[0].data) begin fails++; $display("FAIL fulldeq_head: got %h want %h", bus.deq_data, sb[0].data); end
    step(1'b1, 5'h1F, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.count !== 3'(sb.size())) begin fails++; $display("FAIL fulldeq_count: got %0d want %0d", bus.count, sb.size()); end
    checks++; if (bus.xfer_count !== 16'(mxfer)) begin fails++; $display("FAIL fulldeq_xfer: got %0d want %0d", bus.xfer_count, mxfer); end
    while (sb.size() > 0) begin
      checks++; if (bus.deq_data !== sb[0].data) begin fails++; $display("FAIL fulldeq_drain: got %h want %h", bus.deq_data, sb[0].data); end
      step(1'b0, 5'h0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 5'h15, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.deq_valid, bus.deq_data, bus.deq_orr, bus.deq_andr} !== {1'b1, 5'h15, 1'b1, 1'b0}) begin fails++; $display("FAIL stall%0d: got %b_%h_%b_%b want 1_15_1_0", i, bus.deq_valid, bus.deq_data, bus.deq_orr, bus.deq_andr); end
      step(1'b0, 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    checks++; if (bus.xfer_count !== 16'(mxfer)) begin fails++; $display("FAIL stall_xfer: got %0d want %0d", bus.xfer_count, mxfer); end
    step(1'b0, 5'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 5'(5'h03 + i), 1'b1, 1'b0, 1'b0);
    checks++; if (bus.count !== 3'd3) begin fails++; $display("FAIL mid_count: got %0d want 3", bus.count); end
    #2 ASYNCRESET = 1'b1;
    #1;
    checks++; if (bus.deq_valid !== 1'b0) begin fails++; $display("FAIL mid_deq_valid: got %b want 0", bus.deq_valid); end
    checks++; if (bus.count !== 3'd0) begin fails++; $display("FAIL mid_count_rst: got %0d want 0", bus.count); end
    checks++; if (bus.enq_ready !== 1'b0) begin fails++; $display("FAIL mid_enq_ready: got %b want 0", bus.enq_ready); end
    #1 ASYNCRESET = 1'b0;
    sb.delete(); mxfer = 0;
    step(1'b1, 5'h0A, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.deq_valid !== 1'b1 || bus.deq_data !== 5'h0A) begin fails++; $display("FAIL mid_resume: got %b_%h want 1_0a", bus.deq_valid, bus.deq_data); end
    checks++; if (bus.xfer_count !== 16'(mxfer)) begin fails++; $display("FAIL mid_xfer: got %0d want %0d", bus.xfer_count, mxfer); end
    step(1'b0, 5'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_with_deq();
    test_stall();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
